// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the CPU step/run clock controller.
//   ctrl_state_t        : controller state encoding
//   DEF_DEBOUNCE_CYCLES : stable samples to accept a key change (10 ms at 50 MHz)
//   DEF_RUN_DIV         : cycles between run-mode advances (2 Hz at 50 MHz)
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_RUN_DIV         = 25000000;
   localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one raw active-low pushbutton.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   key_n : raw key level, asynchronous, 0 = pressed
//   press : one-cycle pulse on an accepted released->pressed transition
module key_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          armed;
   logic          streak;
   logic [CW-1:0] cnt;

   // Until a key has been seen stably released after reset, the counter
   // measures the released streak instead of a level change. A key held
   // through reset therefore cannot produce a press until it is let go and
   // pressed again.
   always_comb begin
      streak = 1'b0;
      if (armed) streak = (sync2 != level);
      else       streak = sync2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         armed <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (!streak) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (armed) begin
               level <= sync2;
               press <= ~sync2;
            end else begin
               armed <= 1'b1;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Instruction-advance controller for the single-cycle CPU: single-step and
// run/stop pushbuttons, fixed-rate run mode, permanent stop on CPU halt.
//   CLOCK_50   : system clock
//   reset      : asynchronous active-high reset
//   step_key_n : raw single-step key, 0 = pressed
//   run_key_n  : raw run/stop key, 0 = pressed
//   halt       : CPU halt flag, synchronous
//   cpu_en     : one-cycle advance pulse to the CPU
//   running    : controller is in RUN
//   halted     : controller is in HALTED
//   step_count : number of cpu_en pulses issued, wraps silently
//
// state  | meaning
// IDLE   | stopped; each step press issues one cpu_en
// RUN    | free-running; cpu_en every RUN_DIV cycles
// HALTED | CPU reported halt; nothing issued until reset
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
   parameter int unsigned CNT_W           = DEF_CNT_W
)(
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             step_key_n,
   input  logic             run_key_n,
   input  logic             halt,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);

   localparam int unsigned      DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic             div_tick;
   logic             step_press;
   logic             run_press;
   logic             cpu_en_nxt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk   (CLOCK_50),
      .rst   (reset),
      .key_n (step_key_n),
      .press (step_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
      .clk   (CLOCK_50),
      .rst   (reset),
      .key_n (run_key_n),
      .press (run_press)
   );

   assign div_tick = (div_cnt == DIV_LAST);

   // Priority: halt, then run/stop, then step, then rate tick.
   always_comb begin
      state_nxt  = state;
      cpu_en_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (halt)            state_nxt  = HALTED;
            else if (run_press)  state_nxt  = RUN;
            else if (step_press) cpu_en_nxt = 1'b1;
         end
         RUN: begin
            if (halt)            state_nxt  = HALTED;
            else if (run_press)  state_nxt  = IDLE;
            else if (div_tick)   cpu_en_nxt = 1'b1;
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cpu_en     <= 1'b0;
         div_cnt    <= '0;
         step_count <= '0;
      end else begin
         state  <= state_nxt;
         cpu_en <= cpu_en_nxt;
         // Divider only advances while staying in RUN, so entering RUN
         // always starts a full period.
         if ((state == RUN) && (state_nxt == RUN))
            div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
         else
            div_cnt <= '0;
         if (cpu_en_nxt)
            step_count <= step_count + CNT_W'(1);
      end
   end

   assign running = (state == RUN);
   assign halted  = (state == HALTED);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

   localparam int D  = 4;
   localparam int R  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          step_key_n = 1'b1;
   logic          run_key_n = 1'b1;
   logic          halt = 1'b0;
   logic          cpu_en;
   logic          running;
   logic          halted;
   logic [CW-1:0] step_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int en_log[$];
   int run_rise = -1;
   logic run_prev = 1'b0;

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R), .CNT_W(CW)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .step_key_n (step_key_n),
      .run_key_n  (run_key_n),
      .halt       (halt),
      .cpu_en     (cpu_en),
      .running    (running),
      .halted     (halted),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // Keys: a level change is accepted after D consecutive synchronized samples
   // that disagree with the accepted level; nothing is accepted until D
   // consecutive released samples have been seen since reset.
   // Control: mode 0 idle, 1 run, 2 halted; in run, cpu_en on every R-th edge
   // since entering run.
   bit m_s1[2], m_s2[2], m_lvl[2], m_arm[2], m_press[2], m_raw[2];
   int m_streak[2];
   int m_mode, m_age, m_cnt;
   bit m_en;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1; m_arm[k] = 0;
            m_press[k] = 0; m_streak[k] = 0;
         end
         m_mode = 0; m_age = 0; m_cnt = 0; m_en = 0;
      end else begin
         m_en = 0;
         if (m_mode == 2) begin
         end else if (halt) begin
            m_mode = 2;
         end else if (m_press[1]) begin
            m_mode = (m_mode == 0) ? 1 : 0;
            m_age = 0;
         end else if (m_mode == 0) begin
            if (m_press[0]) m_en = 1;
         end else begin
            m_age++;
            if (m_age % R == 0) m_en = 1;
         end
         if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);

         m_raw[0] = step_key_n;
         m_raw[1] = run_key_n;
         for (int k = 0; k < 2; k++) begin
            m_press[k] = 0;
            if (!m_arm[k]) begin
               m_streak[k] = m_s2[k] ? m_streak[k] + 1 : 0;
               if (m_streak[k] == D) begin m_arm[k] = 1; m_streak[k] = 0; end
            end else begin
               m_streak[k] = (m_s2[k] != m_lvl[k]) ? m_streak[k] + 1 : 0;
               if (m_streak[k] == D) begin
                  m_lvl[k] = m_s2[k];
                  m_press[k] = !m_s2[k];
                  m_streak[k] = 0;
               end
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = m_raw[k];
         end
      end
   end

   // Compare every cycle, away from the edge; also log events for the
   // directed sequences.
   always @(posedge clk) begin
      cyc++;
      #2;
      check("model cpu_en", cpu_en, m_en);
      check("model running", running, m_mode == 1);
      check("model halted", halted, m_mode == 2);
      check("model step_count", step_count, m_cnt);
      if (cpu_en === 1'b1) en_log.push_back(cyc);
      if (running === 1'b1 && !run_prev) run_rise = cyc;
      run_prev = (running === 1'b1);
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic hold_key(input bit which, input int n);
      if (which) run_key_n = 1'b0; else step_key_n = 1'b0;
      repeat (n) @(negedge clk);
      if (which) run_key_n = 1'b1; else step_key_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < target) check("wait_cyc timeout", cyc, target);
   endtask

   typedef struct {
      int low;
      int exp_n;
      int exp_lat;
   } glitch_vec_t;

   glitch_vec_t vecs[6];

   initial begin
      int start;
      int lat;
      int t_step;
      int t_run;

      vecs[0] = '{1, 0, 0};
      vecs[1] = '{2, 0, 0};
      vecs[2] = '{3, 0, 0};
      vecs[3] = '{4, 1, 6};
      vecs[4] = '{5, 1, 6};
      vecs[5] = '{9, 1, 6};

      repeat (3) @(negedge clk);
      check("reset cpu_en", cpu_en, 0);
      check("reset running", running, 0);
      check("reset halted", halted, 0);
      check("reset step_count", step_count, 0);
      reset = 1'b0;
      en_log.delete();
      idle(20);
      check("idle no cpu_en", en_log.size(), 0);

      // step key held low for various lengths from IDLE
      for (int i = 0; i < 6; i++) begin
         en_log.delete();
         start = cyc + 1;
         hold_key(0, vecs[i].low);
         idle(25 - vecs[i].low);
         check($sformatf("glitch%0d pulses", vecs[i].low), en_log.size(), vecs[i].exp_n);
         if (vecs[i].exp_n > 0) begin
            lat = (en_log.size() > 0) ? en_log[0] - start : -1;
            check($sformatf("glitch%0d latency", vecs[i].low), lat, vecs[i].exp_lat);
         end
      end

      // bounce then a solid hold: exactly one pulse, 6 edges after the hold starts
      en_log.delete();
      repeat (3) begin
         hold_key(0, 2);
         idle(1);
      end
      check("bounce no pulse", en_log.size(), 0);
      start = cyc + 1;
      hold_key(0, 10);
      idle(15);
      check("step pulses", en_log.size(), 1);
      lat = (en_log.size() > 0) ? en_log[0] - start : -1;
      check("step latency", lat, 6);
      check("step_count after steps", step_count, 4);

      // run mode; a step press in RUN is ignored; stop lands on a tick edge
      en_log.delete();
      run_rise = -1;
      start = cyc + 1;
      hold_key(1, 6);
      hold_key(0, 6);
      wait_cyc(start + 31);
      hold_key(1, 6);
      idle(12);
      check("run rise", run_rise, start + 6);
      check("run pulses", en_log.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("run pulse%0d", i), (en_log.size() > i) ? en_log[i] : -1, start + 14 + 8 * i);
      check("run stopped", running, 0);
      check("step_count after run", step_count, 7);

      // halt on the terminal-count cycle
      en_log.delete();
      start = cyc + 1;
      hold_key(1, 6);
      wait_cyc(start + 13);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      check("halt blocks cpu_en", cpu_en, 0);
      check("halted set", halted, 1);
      check("halt running", running, 0);
      hold_key(0, 6);
      idle(10);
      hold_key(1, 6);
      idle(10);
      check("halted no pulses", en_log.size(), 0);
      check("halted sticky", halted, 1);
      check("halted step_count", step_count, 7);

      // asynchronous reset in the middle of a clock phase
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("async rst cpu_en", cpu_en, 0);
      check("async rst running", running, 0);
      check("async rst halted", halted, 0);
      check("async rst step_count", step_count, 0);
      @(negedge clk);
      reset = 1'b0;
      en_log.delete();
      idle(20);
      check("post-reset idle", en_log.size(), 0);

      // counter wrap with a 4-bit count
      repeat (17) begin
         hold_key(0, 5);
         idle(10);
      end
      check("wrap step_count", step_count, 1);

      // reset while the run key is mid-debounce and stays held
      run_rise = -1;
      run_key_n = 1'b0;
      idle(4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle(10);
      check("held through reset", running, 0);
      check("held through reset rise", run_rise, -1);
      run_key_n = 1'b1;
      idle(8);
      start = cyc + 1;
      hold_key(1, 6);
      idle(3);
      check("re-press running", running, 1);
      check("re-press rise", run_rise, start + 6);

      // randomized keys, rare halt and reset, checked against the model
      t_step = 1;
      t_run = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 399) == 0) reset = 1'b1;
         halt = ($urandom_range(0, 1499) == 0);
         t_step--;
         if (t_step == 0) begin
            step_key_n = ~step_key_n;
            t_step = $urandom_range(1, 12);
         end
         t_run--;
         if (t_run == 0) begin
            run_key_n = ~run_key_n;
            t_run = $urandom_range(1, 40);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      halt = 1'b0;
      step_key_n = 1'b1;
      run_key_n = 1'b1;
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
